// File: rtl/logic_unit_pkg.sv
// Shared types and the per-bit operator for the registered logic unit.
// The op function is per bit so that any operand width reuses it unchanged.
package logic_unit_pkg;

   typedef enum logic [2:0] {
      OP_NOT  = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_e;

   // x is always the fresh operand, so NOT and PASS ignore z in both modes
   function automatic logic apply_op(input op_e op, input logic x, input logic z);
      logic r;
      case (op)
         OP_NOT:  r = ~x;
         OP_AND:  r = x & z;
         OP_OR:   r = x | z;
         OP_NAND: r = ~(x & z);
         OP_NOR:  r = ~(x | z);
         OP_XOR:  r = x ^ z;
         OP_XNOR: r = ~(x ^ z);
         OP_PASS: r = x;
         default: r = x;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_op_bitwise.sv
// Combinational W-bit operator: applies the selected op bit by bit.
// Shared by the single-beat and accumulate paths of logic_unit_pipe.
module logic_op_bitwise
   import logic_unit_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] x,
   input  logic [W-1:0] z,
   output logic [W-1:0] r
);

   // bit-sliced evaluation of the package operator
   always_comb begin
      r = '0;
      for (int i = 0; i < W; i++) begin
         r[i] = apply_op(op_e'(op), x[i], z[i]);
      end
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered W-bit logic unit with valid/ready on both sides.
// Single mode emits one result per beat; accumulate mode folds a burst into one result.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int W    = 8,
   parameter int CNTW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic [2:0]      op,
   input  logic            acc_mode,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    y,
   output logic            y_zero,
   output logic            y_parity,
   output logic [CNTW-1:0] beats
);

   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   state_e          state_q;
   logic [W-1:0]    acc_q;
   logic [CNTW-1:0] cnt_q;
   logic [2:0]      burst_op_q;
   logic            out_valid_q;
   logic [W-1:0]    y_q;
   logic            y_zero_q;
   logic            y_parity_q;
   logic [CNTW-1:0] beats_q;

   logic            accept_s;
   logic [2:0]      op_sel_d;
   logic [W-1:0]    z_sel_d;
   logic [W-1:0]    fold_d;
   logic [CNTW-1:0] cnt_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready;

   // inside a burst the latched op and the accumulator replace op and b
   always_comb begin
      op_sel_d = op;
      z_sel_d  = b;
      cnt_d    = CNT_ONE;
      if (state_q == ACC) begin
         op_sel_d = burst_op_q;
         z_sel_d  = acc_q;
         cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
         op_sel_d = op;
         z_sel_d  = b;
         cnt_d    = CNT_ONE;
      end
   end

   logic_op_bitwise #(.W(W)) u_op (
      .op (op_sel_d),
      .x  (a),
      .z  (z_sel_d),
      .r  (fold_d)
   );

   // control FSM, accumulator and registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         burst_op_q  <= 3'd0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         y_zero_q    <= 1'b1;
         y_parity_q  <= 1'b0;
         beats_q     <= '0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (accept_s) begin
            case (state_q)
               IDLE: begin
                  if (!acc_mode || in_last) begin
                     y_q         <= fold_d;
                     y_zero_q    <= (fold_d == '0);
                     y_parity_q  <= ^fold_d;
                     beats_q     <= CNT_ONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     acc_q      <= fold_d;
                     cnt_q      <= CNT_ONE;
                     burst_op_q <= op;
                     state_q    <= ACC;
                  end
               end
               ACC: begin
                  acc_q <= fold_d;
                  cnt_q <= cnt_d;
                  if (in_last) begin
                     y_q         <= fold_d;
                     y_zero_q    <= (fold_d == '0);
                     y_parity_q  <= ^fold_d;
                     beats_q     <= cnt_d;
                     out_valid_q <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign y_zero    = y_zero_q;
   assign y_parity  = y_parity_q;
   assign beats     = beats_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: expected results queued at issue time,
// popped by monitors when a result transfers. A second instance uses CNTW=2.
module tb_logic_unit_pipe;

   typedef struct {
      logic [7:0] y;
      logic [3:0] beats;
      logic       zero;
      logic       par;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, acc_mode = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [7:0] a = 8'h00, b = 8'h00;
   logic [2:0] op = 3'd0;
   logic       in_ready, out_valid, y_zero, y_parity;
   logic [7:0] y;
   logic [3:0] beats;

   logic       s_in_valid = 1'b0, s_acc_mode = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b1;
   logic [7:0] s_a = 8'h00, s_b = 8'h00;
   logic [2:0] s_op = 3'd0;
   logic       s_in_ready, s_out_valid, s_y_zero, s_y_parity;
   logic [7:0] s_y;
   logic [1:0] s_beats;

   exp_t exp_q[$];
   exp_t sat_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic_unit_pipe #(.W(8), .CNTW(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc_mode(acc_mode), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .y(y),
      .y_zero(y_zero), .y_parity(y_parity), .beats(beats)
   );

   logic_unit_pipe #(.W(8), .CNTW(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .op(s_op), .acc_mode(s_acc_mode), .in_last(s_in_last),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y),
      .y_zero(s_y_zero), .y_parity(s_y_parity), .beats(s_beats)
   );

   function automatic exp_t mk(input logic [7:0] ey, input logic [3:0] eb, input int due);
      exp_t e;
      e.y = ey; e.beats = eb; e.zero = (ey == 8'h00); e.par = ^ey; e.due = due;
      return e;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                       input logic tacc, input logic tlast, input bit produce,
                       input logic [7:0] ey, input logic [3:0] eb);
      bit got = 1'b0;
      a = ta; b = tb_; op = top; acc_mode = tacc; in_last = tlast; in_valid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL send_timeout: got no in_ready expected in_ready=1");
      end else if (produce) begin
         exp_q.push_back(mk(ey, eb, cyc));
      end
   endtask

   task automatic drain;
      int k = 0;
      while ((exp_q.size() != 0 || sat_q.size() != 0) && k < 100) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (exp_q.size() != 0 || sat_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_q.size(), sat_q.size());
         exp_q.delete();
         sat_q.delete();
      end
   endtask

   // main-instance monitor: latency on first presentation, contents on transfer
   initial begin
      bit seen = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_valid: got y=%h beats=%0d expected no output", y, beats);
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  total++;
                  if (cyc != exp_q[0].due) begin
                     bad++;
                     $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, exp_q[0].due);
                  end
               end
               if (out_ready) begin
                  e = exp_q.pop_front();
                  seen = 1'b0;
                  total++;
                  if (y !== e.y || beats !== e.beats || y_zero !== e.zero || y_parity !== e.par) begin
                     bad++;
                     $display("FAIL result: got y=%h beats=%0d z=%b p=%b expected y=%h beats=%0d z=%b p=%b",
                              y, beats, y_zero, y_parity, e.y, e.beats, e.zero, e.par);
                  end
               end
            end
         end
      end
   end

   // saturation-instance monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && s_out_valid) begin
            total++;
            if (sat_q.size() == 0) begin
               bad++;
               $display("FAIL sat_unexpected_valid: got y=%h expected no output", s_y);
            end else begin
               e = sat_q.pop_front();
               if (s_y !== e.y || {2'b00, s_beats} !== e.beats || s_y_zero !== e.zero ||
                   s_y_parity !== e.par || cyc != e.due) begin
                  bad++;
                  $display("FAIL sat_result: got y=%h beats=%0d p=%b cyc=%0d expected y=%h beats=%0d p=%b cyc=%0d",
                           s_y, s_beats, s_y_parity, cyc, e.y, e.beats, e.par, e.due);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] single_exp [8];
      single_exp = '{8'h0F, 8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {7'd0, out_valid}, 8'h00);
      chk("reset_y", y, 8'h00);
      chk("reset_y_zero", {7'd0, y_zero}, 8'h01);
      chk("reset_y_parity", {7'd0, y_parity}, 8'h00);
      chk("reset_beats", {4'd0, beats}, 8'h00);
      chk("reset_in_ready", {7'd0, in_ready}, 8'h01);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0, 1'b1, single_exp[i], 4'd1);
      end
      send(8'h01, 8'h00, 3'd2, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1);
      send(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd1);
      drain();

      // XOR burst; later beats carry a different op and acc_mode=0 to be ignored
      send(8'h01, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
      send(8'h02, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
      send(8'h04, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
      send(8'h08, 8'hFF, 3'd1, 1'b0, 1'b1, 1'b1, 8'h0F, 4'd4);
      drain();

      out_ready = 1'b0;
      send(8'hFF, 8'hAA, 3'd1, 1'b0, 1'b0, 1'b1, 8'hAA, 4'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_y", y, 8'hAA);
         chk("stall_out_valid", {7'd0, out_valid}, 8'h01);
         chk("stall_in_ready", {7'd0, in_ready}, 8'h00);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(8'hF0, 8'h3C, 3'd5, 1'b0, 1'b0, 1'b1, 8'hCC, 4'd1);
      drain();

      send(8'h10, 8'h01, 3'd2, 1'b1, 1'b1, 1'b1, 8'h11, 4'd1);
      send(8'hF0, 8'h3C, 3'd7, 1'b0, 1'b0, 1'b1, 8'hF0, 4'd1);
      drain();

      send(8'h01, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
      send(8'h02, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset_out_valid", {7'd0, out_valid}, 8'h00);
      chk("midreset_beats", {4'd0, beats}, 8'h00);
      chk("midreset_in_ready", {7'd0, in_ready}, 8'h01);
      @(posedge clk);
      #1;
      send(8'h00, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd1);
      drain();

      // 5-beat AND burst on the CNTW=2 instance
      for (int i = 0; i < 5; i++) begin
         s_a = 8'hFF; s_b = 8'hFF; s_op = 3'd1; s_acc_mode = 1'b1;
         s_in_last = (i == 4); s_in_valid = 1'b1;
         @(negedge clk);
         chk("sat_in_ready", {7'd0, s_in_ready}, 8'h01);
         chk("sat_no_early_valid", {7'd0, s_out_valid}, 8'h00);
         @(posedge clk);
         #1;
      end
      s_in_valid = 1'b0;
      sat_q.push_back(mk(8'hFF, 4'd3, cyc));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the two-input gate block.
- Applies one of eight bitwise ops to W-bit operands, selected per beat by an opcode, instead of driving all seven 1-bit gate outputs at once.
- Runs in two modes:
  - single mode: one result per beat;
  - accumulate mode: folds a burst of operands into one result, emitted on the last beat.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
W, 8, operand/result width in bits (>=1)
CNTW, 4, width of the burst beat counter; counter saturates at 2^CNTW-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  W  operand A
b  input  W  operand B (ignored on accumulate beats after the first)
op  input  3  opcode: 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a
acc_mode  input  1  1 = accumulate burst, 0 = single; sampled on the first beat of a burst only
in_last  input  1  marks final beat of an accumulate burst; ignored in single mode
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  W  result
y_zero  output  1  y == 0
y_parity  output  1  XOR-reduction of y
beats  output  CNTW  beats folded into y (1 in single mode), saturating

Behaviour:
- Reset values:
  - out_valid=0, y=0, y_zero=1, y_parity=0, beats=0.
  - FSM goes to IDLE; internal accumulator and counter are cleared.
  - in_ready=1 in the cycle after reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - The result transfers when out_valid && out_ready.
  - y, y_zero, y_parity and beats stay stable while out_valid && !out_ready.
- Latency: a beat accepted in cycle N that produces a result gives out_valid=1 in cycle N+1. Throughput is 1 beat/cycle when out_ready is held high.
- Op function f(x,z): NOT → ~x; AND x&z; OR x|z; NAND ~(x&z); NOR ~(x|z); XOR x^z; XNOR ~(x^z); PASS → x.
- FSM states:
  - IDLE. On an accepted beat:
    - if acc_mode=0: y ← f(a,b), beats ← 1, out_valid ← 1, stay IDLE.
    - if acc_mode=1 and in_last=1: same as single mode (burst of one), stay IDLE.
    - if acc_mode=1 and in_last=0: acc ← f(a,b), cnt ← 1, latch op into burst_op, go ACC, no output.
  - ACC. On an accepted beat:
    - acc ← f'(acc, a), where f' is f with operands (acc, a) and NOT/PASS apply to a alone.
    - cnt ← cnt+1, saturating.
    - The beat's op and acc_mode inputs are ignored; burst_op is used.
    - If in_last: y ← the new acc, beats ← the new cnt, out_valid ← 1, go IDLE.
- Intermediate accumulate beats are still gated by in_ready. They do not disturb a pending output.
- y_zero and y_parity are registered together with y and are consistent with it.
- Counter saturation: a burst longer than 2^CNTW-1 beats reports beats = 2^CNTW-1; the data fold is still correct.
- Reset mid-burst or mid-stall discards acc, cnt and any pending result; no partial result is emitted.
- Simultaneous output transfer and input accept in the same cycle is legal; the new result replaces the old one with no bubble.
- in_valid low in ACC: the state holds indefinitely.

Decomposition:
- Package logic_unit_pkg holds:
  - enum op_e for the eight opcodes (3 bits);
  - enum state_e {IDLE, ACC};
  - a function apply_op(op, x, z) returning W bits, written as a parametrised function or instantiated per width.
- One natural sub-module, logic_op_bitwise: combinational, W-bit, op-selected function shared by the IDLE and ACC paths.

Test Plan:
- Single mode, W=8, a=8'hF0, b=8'h3C, each op 0..7 back-to-back with out_ready=1 → y = 0F,30,FC,CF,03,CC,33,F0 on consecutive cycles; beats=1; y_parity of 8'h30 = 0.
- Accumulate XOR burst a=01,02,04,08 (b=00 on first beat), in_last on 4th → single result y=0F, beats=4, y_zero=0; no out_valid during beats 1-3.
- Backpressure: single AND a=FF,b=AA with out_ready=0 for 3 cycles → y=AA held stable; in_ready=0; next beat accepted in the same cycle out_ready rises, with no bubble.
- Burst of one: acc_mode=1, in_last=1, op OR, a=10, b=01 → y=11, beats=1, FSM stays IDLE.
- Saturation with CNTW=2: 5-beat AND burst of all FF → y=FF, beats=3, y_parity=0.
- Reset mid-burst: rst pulsed after 2 of 4 beats, then a new single XNOR a=00,b=00 → out_valid=0 through reset; next y=FF, beats=1; no stale accumulator output.
